ycr1_imem_sram_resp: RTL



---
 rtl/ycr1_imem_sram_resp_pkg.sv | 21 ++
 rtl/ycr1_imem_sram_resp_if.sv | 23 ++
 rtl/ycr1_imem_sram_resp.sv | 117 +++++++++++
 3 files changed

// File: rtl/ycr1_imem_sram_resp_pkg.sv
// Shared IMEM interface constants (command/response encodings, bus widths)
// used by the IMEM SRAM responder and its surroundings.
package ycr1_imem_sram_resp_pkg;

   localparam int YCR1_IMEM_AWIDTH = 32;
   localparam int YCR1_IMEM_DWIDTH = 32;
   localparam int YCR1_IMEM_BSIZE  = 3;

   localparam logic YCR1_MEM_CMD_RD = 1'b0;
   localparam logic YCR1_MEM_CMD_WR = 1'b1;

   localparam logic [1:0] YCR1_MEM_RESP_NOTRDY = 2'b00;
   localparam logic [1:0] YCR1_MEM_RESP_RDY_OK = 2'b01;
   localparam logic [1:0] YCR1_MEM_RESP_RDY_ER = 2'b10;

   // A zero burst length still moves one word.
   function automatic logic [YCR1_IMEM_BSIZE-1:0] burst_len(input logic [YCR1_IMEM_BSIZE-1:0] bl);
      return (bl == '0) ? YCR1_IMEM_BSIZE'(1) : bl;
   endfunction

endpackage

// File: rtl/ycr1_imem_sram_resp_if.sv
// Core IMEM request/response bus; master = requester, slave = responder.
interface ycr1_imem_sram_resp_if;
   import ycr1_imem_sram_resp_pkg::*;

   logic                        imem_req_ack;
   logic                        imem_req;
   logic                        imem_cmd;
   logic [YCR1_IMEM_AWIDTH-1:0] imem_addr;
   logic [YCR1_IMEM_BSIZE-1:0]  imem_bl;
   logic [YCR1_IMEM_DWIDTH-1:0] imem_rdata;
   logic [1:0]                  imem_resp;

   modport master (
      output imem_req, imem_cmd, imem_addr, imem_bl,
      input  imem_req_ack, imem_rdata, imem_resp
   );

   modport slave (
      input  imem_req, imem_cmd, imem_addr, imem_bl,
      output imem_req_ack, imem_rdata, imem_resp
   );

endinterface

// File: rtl/ycr1_imem_sram_resp.sv
// IMEM responder: turns single/burst instruction reads into 1-cycle-latency
// SRAM reads, one RDY_OK beat per word; writes and misaligned reads get RDY_ER.
module ycr1_imem_sram_resp
   import ycr1_imem_sram_resp_pkg::*;
#(
   parameter int SRAM_AWIDTH = 9,
   parameter int ADDR_LSB    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ycr1_imem_sram_resp_if.slave   imem,
   output logic                   sram_csb,
   output logic [SRAM_AWIDTH-1:0] sram_addr,
   input  logic [31:0]            sram_dout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR  = 2'd2
   } type_ycr1_imem_resp_fsm_e;

   type_ycr1_imem_resp_fsm_e     r_fsm, w_fsm_nxt;
   logic [YCR1_IMEM_BSIZE-1:0]   r_beats_left, w_beats_nxt;
   logic [YCR1_IMEM_BSIZE-1:0]   r_issue_left, w_issue_nxt;
   logic [SRAM_AWIDTH-1:0]       r_addr_cnt, w_addr_nxt;

   logic                         w_ack;
   logic                         w_accept;
   logic                         w_good;
   logic [SRAM_AWIDTH-1:0]       w_start;
   logic [YCR1_IMEM_BSIZE-1:0]   w_n;
   logic                         w_csb;
   logic [SRAM_AWIDTH-1:0]       w_sram_addr;
   logic [1:0]                   w_resp;
   logic [YCR1_IMEM_DWIDTH-1:0]  w_rdata;
   logic                         w_unused_addr;

   // Bits above the SRAM range belong to the router's decode.
   assign w_unused_addr = ^imem.imem_addr;

   assign w_ack    = (r_fsm == ST_IDLE) | (r_fsm == ST_ERR) |
                     ((r_fsm == ST_DATA) & (r_beats_left == YCR1_IMEM_BSIZE'(1)));
   // Gated by reset so no SRAM read is launched while reset is held.
   assign w_accept = imem.imem_req & w_ack & rst_n;
   assign w_good   = (imem.imem_cmd == YCR1_MEM_CMD_RD) & (imem.imem_addr[ADDR_LSB-1:0] == '0);
   assign w_start  = imem.imem_addr[ADDR_LSB +: SRAM_AWIDTH];
   assign w_n      = burst_len(imem.imem_bl);

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_beats_nxt = r_beats_left;
      w_issue_nxt = r_issue_left;
      w_addr_nxt  = r_addr_cnt;
      w_csb       = 1'b1;
      w_sram_addr = r_addr_cnt;
      w_resp      = YCR1_MEM_RESP_NOTRDY;
      w_rdata     = '0;

      case (r_fsm)
         ST_DATA: begin
            w_resp      = YCR1_MEM_RESP_RDY_OK;
            w_rdata     = sram_dout;
            w_beats_nxt = r_beats_left - YCR1_IMEM_BSIZE'(1);
            // Reads run one cycle ahead of beats, so issue stops one early.
            if (r_issue_left != '0) begin
               w_csb       = 1'b0;
               w_issue_nxt = r_issue_left - YCR1_IMEM_BSIZE'(1);
               w_addr_nxt  = r_addr_cnt + SRAM_AWIDTH'(1);
            end
            if (r_beats_left == YCR1_IMEM_BSIZE'(1))
               w_fsm_nxt = ST_IDLE;
         end
         ST_ERR: begin
            w_resp    = YCR1_MEM_RESP_RDY_ER;
            w_fsm_nxt = ST_IDLE;
         end
         default: ;
      endcase

      // On the final beat issue_left is already 0, so this never collides
      // with an in-flight read.
      if (w_accept) begin
         if (w_good) begin
            w_csb       = 1'b0;
            w_sram_addr = w_start;
            w_beats_nxt = w_n;
            w_issue_nxt = w_n - YCR1_IMEM_BSIZE'(1);
            w_addr_nxt  = w_start + SRAM_AWIDTH'(1);
            w_fsm_nxt   = ST_DATA;
         end else begin
            w_fsm_nxt   = ST_ERR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm        <= ST_IDLE;
         r_beats_left <= '0;
         r_issue_left <= '0;
         r_addr_cnt   <= '0;
      end else begin
         r_fsm        <= w_fsm_nxt;
         r_beats_left <= w_beats_nxt;
         r_issue_left <= w_issue_nxt;
         r_addr_cnt   <= w_addr_nxt;
      end
   end

   assign imem.imem_req_ack = w_ack;
   assign imem.imem_resp    = w_resp;
   assign imem.imem_rdata   = w_rdata;
   assign sram_csb          = w_csb;
   assign sram_addr         = w_sram_addr;

endmodule
